// File: rtl/sudoku_check_sched_if.sv
// sudoku_check_sched_if: read bus between the checker and the grid cell store
interface sudoku_check_sched_if;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [3:0] rd_data;
  modport master (output rd_en, rd_addr, input rd_data);
  modport slave (input rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/sudoku_check_sched.sv
// sudoku_check_sched: streams all 27 sudoku units from the cell store and flags the first rule violation
module sudoku_check_sched #(
  parameter bit STOP_ON_ERR = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  sudoku_check_sched_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_unit,
  output logic [3:0]                  err_index
);
  typedef enum logic [2:0] {IDLE, ROW, COL, BOX, FLUSH, DONE} state_t;
  state_t state, nxt;
  logic [3:0] u, k, r, c, pi;
  logic [1:0] pu;
  logic v, pk0, bad, stop, go, kill, last;
  logic [8:0] mask, base, nmask;
  always_comb begin
    base = pk0 ? '0 : mask;
    bad = v && (bus.rd_data > 4'd9 || (bus.rd_data != 4'd0 && base[bus.rd_data - 4'd1]));
    nmask = (bus.rd_data != 4'd0 && bus.rd_data <= 4'd9) ? base | (9'd1 << (bus.rd_data - 4'd1)) : base;
    bus.rd_en = state inside {ROW, COL, BOX};
    busy = bus.rd_en || state == FLUSH;
    done = state == DONE;
    r = state == ROW ? u : state == COL ? k : 4'(u / 3 * 3 + k / 3);
    c = state == ROW ? k : state == COL ? u : 4'(u % 3 * 3 + k % 3);
    bus.rd_addr = bus.rd_en ? 7'(r) * 7'd9 + 7'(c) : '0;
    last = u == 4'd8 && k == 4'd8;
    stop = STOP_ON_ERR && bad && bus.rd_en;
    go = (state == IDLE || state == DONE) && start && !abort;
    kill = busy ? abort : state == DONE && abort && !start;
    nxt = state;
    if (go) nxt = ROW;
    else if (kill) nxt = IDLE;
    else if (state == FLUSH) nxt = DONE;
    else if (stop) nxt = FLUSH;
    else if (bus.rd_en && last) nxt = state == ROW ? COL : state == COL ? BOX : FLUSH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {u, k, pi, pu, v, pk0, mask, err, err_unit, err_index} <= '0;
    end else begin
      state <= nxt;
      k <= bus.rd_en && k != 4'd8 ? k + 4'd1 : '0;
      u <= !bus.rd_en ? '0 : k != 4'd8 ? u : last ? '0 : u + 4'd1;
      // tag of the read in flight, so errors are charged to the unit whose data is consumed
      v <= bus.rd_en && !stop && !kill;
      pu <= state == ROW ? 2'd0 : state == COL ? 2'd1 : 2'd2;
      pi <= u;
      pk0 <= k == 4'd0;
      if (v) mask <= nmask;
      if (go || kill) {err, err_unit, err_index} <= '0;
      else if (bad && !err) begin
        err <= 1'b1;
        err_unit <= pu;
        err_index <= pi;
      end
    end
  end
endmodule

// File: doc/sudoku_check_sched.md
SUDOKU_CHECK_SCHED -- requirements
Module: sudoku_check_sched

Interface
REQ-001 Parameter: STOP_ON_ERR, default 0, 1 = end the check on the first detected error.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request a full grid check; sampled only in IDLE.
REQ-005 Port: abort  input  1  cancel a check in progress.
REQ-006 Port: rd_en  output  1  grid read strobe to the cell store.
REQ-007 Port: rd_addr  output  7  cell index, row*9+col, range 0..80.
REQ-008 Port: rd_data  input  4  cell value; valid exactly one cycle after rd_en.
REQ-009 Port: busy  output  1  check in progress.
REQ-010 Port: done  output  1  check completed; held until the next accepted start, abort or rst.
REQ-011 Port: err  output  1  at least one rule violation detected in the current or last check.
REQ-012 Port: err_unit  output  2  unit type of the first error: 0 row, 1 column, 2 box; 3 never driven.
REQ-013 Port: err_index  output  4  unit number of the first error, 0..8.

Function
REQ-014 The FSM SHALL have states IDLE, ROW, COL, BOX, FLUSH and DONE; DONE behaves as IDLE for start and abort handling.
REQ-015 start=1 in IDLE/DONE with abort=0 SHALL enter ROW on that edge, set busy=1, and clear done, err, err_unit and err_index.
REQ-016 start while busy SHALL be ignored; start and abort together in IDLE/DONE SHALL be ignored.
REQ-017 Each of ROW, COL and BOX SHALL scan units u=0..8 and positions k=0..8 with k fastest, issuing one read per cycle and never idling between cells, units or phases.
REQ-018 Addresses SHALL be: ROW u*9+k; COL k*9+u; BOX ((u/3)*3+k/3)*9 + (u%3)*3 + k%3, using integer division.
REQ-019 rd_en SHALL be high for exactly 243 consecutive cycles, beginning the cycle after start is accepted.
REQ-020 After the last read, the FSM SHALL enter FLUSH for one cycle to consume the final rd_data.
REQ-021 A 9-bit seen-mask SHALL cover each unit; the mask SHALL be treated as zero for the data of k=0 of every unit.
REQ-022 Value 0 SHALL be treated as empty: no mask update and no error.
REQ-023 Value 1..9 SHALL be checked against mask bit value-1: error if already set, otherwise set that bit.
REQ-024 Value 10..15 SHALL count as an error in the current unit.
REQ-025 On the first error, err SHALL go to 1 and err_unit/err_index SHALL latch the unit of the consumed data, not the read being issued; later errors SHALL leave these unchanged.
REQ-026 done=1 and busy=0 SHALL take effect on the edge that consumes the 243rd rd_data, i.e. exactly 244 edges after the start edge.
REQ-027 With STOP_ON_ERR=1, rd_en SHALL drop on the edge the first error is consumed, the one in-flight read SHALL be discarded, and done=1 with busy=0 SHALL follow on the next edge.
REQ-028 abort while busy SHALL return to IDLE on that edge: rd_en=0, busy=0, done=0, err cleared, and in-flight data discarded.
REQ-029 rd_addr SHALL be 0 whenever rd_en=0.

Reset
REQ-030 rst=1 SHALL force IDLE and set rd_en=0, rd_addr=0, busy=0, done=0, err=0, err_unit=0, err_index=0, and clear the mask, from any state including mid-scan.
REQ-031 rst SHALL take priority over start and abort.

Verification
REQ-032 Valid solved grid, start pulse -> 243 reads with the exact REQ-018 address order; done=1 at edge 244; err=0.
REQ-033 All-zero grid -> done=1 at edge 244, err=0.
REQ-034 5 at (3,0) and (3,4), rest 0 -> err=1, err_unit=0, err_index=3.
REQ-035 7 at (0,7) and (8,7), rest 0 -> err_unit=1, err_index=7; 2 at (3,3) and (5,5) only -> err_unit=2, err_index=4.
REQ-036 Value 12 at (0,0) with STOP_ON_ERR=1 -> err_unit=0, err_index=0; rd_en low after 2 reads; done one edge later.
REQ-037 abort at cycle 100 -> busy=0, rd_en=0, done=0 next cycle; start during busy ignored; rst at cycle 150 -> all outputs 0.
